au_op_sequencer: RTL and testbench

Issue and capture stage placed directly upstream of the 32-bit arithmetic unit. It buffers operation requests in a small FIFO and presents each one to the unit with stable operands and opcode. It waits the fixed latency for that opcode, then captures the sum or hi/lo result and computes the zero and divide-by-zero flags. It holds the result on a valid/ready response port until the consumer accepts it.

---
 rtl/au_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_au_op_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_op_sequencer.sv
// Issue/capture stage in front of the 32-bit arithmetic unit.
// Buffers requests, holds operands for the op latency, captures results.
module au_op_sequencer #(
    parameter int DEPTH      = 2,
    parameter int ADDSUB_LAT = 1,
    parameter int MULDIV_LAT = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    output logic [31:0] au_a,
    output logic [31:0] au_b,
    output logic [1:0]  au_op,
    output logic        au_start,
    input  logic [31:0] au_s,
    input  logic [31:0] au_hi,
    input  logic [31:0] au_lo,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_zero,
    output logic        rsp_dz
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAXL = (ADDSUB_LAT > MULDIV_LAT) ? ADDSUB_LAT : MULDIV_LAT;
    localparam int CW   = $clog2(MAXL) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [65:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            r_oor;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_au_a;
    logic [31:0]     r_au_b;
    logic [1:0]      r_au_op;
    logic            r_start;
    logic [31:0]     r_rsp_hi;
    logic [31:0]     r_rsp_lo;
    logic            r_rsp_zero;
    logic            r_rsp_dz;

    logic            w_push;
    logic            w_pop;
    logic            w_cap;
    logic            w_empty;
    logic [65:0]     w_head;
    logic [CW-1:0]   w_lat;
    logic [31:0]     w_hi;
    logic [31:0]     w_lo;
    logic            w_zero;
    logic            w_dz;

    assign w_empty   = (r_count == '0);
    assign req_ready = r_oor && (r_count != (AW+1)'(DEPTH));
    assign w_push    = req_valid && req_ready;
    assign w_head    = r_mem[r_rptr];
    assign w_lat     = w_head[65] ? CW'(MULDIV_LAT - 1) : CW'(ADDSUB_LAT - 1);

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_cap  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_cap  = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = S_EXEC;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Result shaping depends on the latched opcode, not the FIFO head
    always_comb begin
        w_hi   = 32'd0;
        w_lo   = au_s;
        w_zero = (au_s == 32'd0);
        if (r_au_op[1]) begin
            w_hi   = au_hi;
            w_lo   = au_lo;
            w_zero = r_au_op[0] ? (au_lo == 32'd0)
                                : ({au_hi, au_lo} == 64'd0);
        end
        w_dz = (r_au_op == 2'b11) && (r_au_b == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {req_op, req_a, req_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oor      <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_cnt      <= '0;
            r_au_a     <= 32'd0;
            r_au_b     <= 32'd0;
            r_au_op    <= 2'b00;
            r_start    <= 1'b0;
            r_rsp_hi   <= 32'd0;
            r_rsp_lo   <= 32'd0;
            r_rsp_zero <= 1'b0;
            r_rsp_dz   <= 1'b0;
        end else begin
            r_oor   <= 1'b1;
            r_start <= w_pop;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                r_au_op <= w_head[65:64];
                r_au_a  <= w_head[63:32];
                r_au_b  <= w_head[31:0];
                r_cnt   <= w_lat;
            end else if (r_state == S_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_cap) begin
                r_rsp_hi   <= w_hi;
                r_rsp_lo   <= w_lo;
                r_rsp_zero <= w_zero;
                r_rsp_dz   <= w_dz;
            end
        end
    end

    assign au_a      = r_au_a;
    assign au_b      = r_au_b;
    assign au_op     = r_au_op;
    assign au_start  = r_start;
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_hi    = r_rsp_hi;
    assign rsp_lo    = r_rsp_lo;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_dz    = r_rsp_dz;

endmodule

// File: tb/tb_au_op_sequencer.sv
// Bench for au_op_sequencer: latency-accurate AU model, queue-based
// reference of expected responses, directed cases then random traffic.
module tb_au_op_sequencer;

    localparam int LAT_AS = 1;
    localparam int LAT_MD = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic [31:0] au_a;
    logic [31:0] au_b;
    logic [1:0]  au_op;
    logic        au_start;
    logic [31:0] au_s;
    logic [31:0] au_hi;
    logic [31:0] au_lo;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_zero;
    logic        rsp_dz;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int au_n   = 0;

    logic [65:0] q[$];
    int          hs_cyc[$];
    logic [65:0] prev_rsp;
    logic        prev_hold = 1'b0;

    au_op_sequencer #(
        .DEPTH(2), .ADDSUB_LAT(LAT_AS), .MULDIV_LAT(LAT_MD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_start(au_start),
        .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
        .rsp_zero(rsp_zero), .rsp_dz(rsp_dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AU: results only become correct in the last cycle of the op latency
    always @(posedge clk) begin
        if (au_start) au_n <= 1;
        else          au_n <= au_n + 1;
    end

    always_comb begin
        logic [63:0] p;
        logic [31:0] s, hi, lo;
        int          lat;
        logic        ok;
        p   = 64'(au_a) * 64'(au_b);
        s   = au_op[0] ? au_a - au_b : au_a + au_b;
        hi  = p[63:32];
        lo  = p[31:0];
        if (au_op == 2'b11) begin
            hi = (au_b == 0) ? au_a : au_a % au_b;
            lo = (au_b == 0) ? 32'hFFFF_FFFF : au_a / au_b;
        end
        lat = au_op[1] ? LAT_MD : LAT_AS;
        ok  = au_start ? (lat == 1) : (au_n + 1 >= lat);
        au_s  = ok ? s  : ~s;
        au_hi = ok ? hi : ~hi;
        au_lo = ok ? lo : ~lo;
    end

    function automatic logic [65:0] model(input logic [65:0] r);
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] p;
        logic        z;
        op = r[65:64];
        a  = r[63:32];
        b  = r[31:0];
        p  = 64'(a) * 64'(b);
        hi = 32'd0;
        case (op)
            2'b00: lo = a + b;
            2'b01: lo = a - b;
            2'b10: begin hi = p[63:32]; lo = p[31:0]; end
            default: begin
                hi = (b == 0) ? a : a % b;
                lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
            end
        endcase
        z = (op == 2'b10) ? ({hi, lo} == 64'd0) : (lo == 32'd0);
        return {hi, lo, z, (op == 2'b11) && (b == 32'd0)};
    endfunction

    always @(negedge clk) begin
        logic [65:0] e;
        logic [65:0] cur;
        cur = {rsp_hi, rsp_lo, rsp_zero, rsp_dz};
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && rsp_valid) chk("hold", 72'(cur), 72'(prev_rsp));
            if (req_valid && req_ready) q.push_back({req_op, req_a, req_b});
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", 72'(1), 72'(0));
                end else begin
                    e = q.pop_front();
                    chk("rsp", 72'(cur), 72'(model(e)));
                end
                hs_cyc.push_back(cyc);
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = cur;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op);
        logic acc;
        int   n;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 400);
        if (!acc) chk("req_timeout", 72'(0), 72'(1));
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n, output int starts);
        n = 0; starts = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (au_start) starts++;
        end
        if (!rsp_valid) chk("rsp_timeout", 72'(0), 72'(1));
    endtask

    initial begin
        int n, st, base, seen;
        logic done;
        rst_n = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
        req_a = 32'd1; req_b = 32'd2; req_op = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_au", 72'({au_a, au_b, au_op, au_start}), 72'(0));
        chk("rst_rsp", 72'({rsp_valid, rsp_hi, rsp_lo, rsp_zero, rsp_dz,
                            req_ready}), 72'(0));
        req_valid = 1'b0;
        rst_n = 1'b1;
        chk("ready_pre_edge", 72'(req_ready), 72'(0));
        @(posedge clk); #1;
        chk("ready_after_rel", 72'(req_ready), 72'(1));

        send(32'd5, 32'd7, 2'b00);
        wait_rsp(n, st);
        chk("add_lat", 72'(n), 72'(LAT_AS + 1));
        chk("add_res", 72'({rsp_hi, rsp_lo, rsp_zero}), 72'({32'd0, 32'd12, 1'b0}));
        @(posedge clk); #1;

        send(32'd9, 32'd9, 2'b01);
        wait_rsp(n, st);
        chk("sub_res", 72'({rsp_lo, rsp_zero}), 72'({32'd0, 1'b1}));
        @(posedge clk); #1;

        send(32'h0001_0000, 32'h0001_0000, 2'b10);
        wait_rsp(n, st);
        chk("mul_lat", 72'(n), 72'(LAT_MD + 1));
        chk("mul_start", 72'(st), 72'(1));
        chk("mul_res", 72'({rsp_hi, rsp_lo, rsp_zero}), 72'({32'd1, 32'd0, 1'b0}));
        @(posedge clk); #1;

        send(32'd100, 32'd0, 2'b11);
        wait_rsp(n, st);
        chk("dz_res", 72'({rsp_hi, rsp_lo, rsp_dz}),
            72'({32'd100, 32'hFFFF_FFFF, 1'b1}));
        @(posedge clk); #1;
        send(32'd100, 32'd7, 2'b11);
        wait_rsp(n, st);
        chk("div_res", 72'({rsp_hi, rsp_lo, rsp_dz}), 72'({32'd2, 32'd14, 1'b0}));
        @(posedge clk); #1;

        rsp_ready = 1'b0;
        send(32'd1, 32'd2, 2'b00);
        send(32'd3, 32'd4, 2'b00);
        send(32'd5, 32'd6, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("full_ready", 72'(req_ready), 72'(0));
        chk("bp_first", 72'({rsp_valid, rsp_lo}), 72'({1'b1, 32'd3}));
        base = hs_cyc.size();
        rsp_ready = 1'b1;
        n = 0;
        while (hs_cyc.size() < base + 3 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (hs_cyc.size() < base + 3) begin
            chk("bp_timeout", 72'(0), 72'(1));
        end else begin
            chk("b2b_gap1", 72'(hs_cyc[base+1] - hs_cyc[base]), 72'(LAT_AS + 1));
            chk("b2b_gap2", 72'(hs_cyc[base+2] - hs_cyc[base+1]), 72'(LAT_AS + 1));
        end

        send(32'd3, 32'd5, 2'b10);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp", 72'({rsp_valid, rsp_hi, rsp_lo, req_ready}), 72'(0));
        chk("mid_rst_au", 72'({au_a, au_b, au_op, au_start}), 72'(0));
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid || au_start) seen++;
        end
        chk("flushed", 72'(seen), 72'(0));
        send(32'd5, 32'd7, 2'b00);
        wait_rsp(n, st);
        chk("post_rst_add", 72'({rsp_lo, n}), 72'({32'd12, 32'(LAT_AS + 1)}));
        @(posedge clk); #1;

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a, b;
                    logic [1:0]  op;
                    op = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 2) != 0) op[1] = 1'b0;
                    a = $urandom;
                    b = $urandom;
                    if ($urandom_range(0, 7) == 0) b = 32'd0;
                    if ($urandom_range(0, 7) == 0) begin
                        b = a; op = 2'b01;
                    end
                    if ($urandom_range(0, 9) == 0) a = 32'd0;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(a, b, op);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 72'(q.size()), 72'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
